// File: rtl/alu_issue_stage.sv
// ID/EX issue stage for the 32-bit compare/add ALU: decode, operand forwarding, load-use stall, output register.
// Optional ALU_ISSUE_STATS_EN adds saturating issue/stall counters.
module alu_issue_stage #(
  parameter int DATA_W = 32,
  parameter int IMM_W  = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [5:0]        in_opcode,
  input  logic [5:0]        in_func,
  input  logic [4:0]        in_rs1,
  input  logic [4:0]        in_rs2,
  input  logic [4:0]        in_rd,
  input  logic [DATA_W-1:0] in_rs1_data,
  input  logic [DATA_W-1:0] in_rs2_data,
  input  logic [IMM_W-1:0]  in_imm,
  input  logic              exmem_wr_en,
  input  logic [4:0]        exmem_rd,
  input  logic [DATA_W-1:0] exmem_data,
  input  logic              memwb_wr_en,
  input  logic [4:0]        memwb_rd,
  input  logic [DATA_W-1:0] memwb_data,
  input  logic              ex_load_pending,
  input  logic [4:0]        ex_load_rd,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_in1,
  output logic [DATA_W-1:0] out_in2,
  output logic [4:0]        out_sel,
  output logic [4:0]        out_rd,
  output logic              out_wr_en,
  output logic              out_illegal
`ifdef ALU_ISSUE_STATS_EN
  ,
  output logic [31:0]       stat_issued,
  output logic [31:0]       stat_stalls
`endif
);

  localparam logic [4:0] SEL_ADD = 5'b00000;
  localparam logic [4:0] SEL_SUB = 5'b11000;
  localparam logic [4:0] SEL_SEQ = 5'b10000;
  localparam logic [4:0] SEL_SNE = 5'b10001;
  localparam logic [4:0] SEL_SLT = 5'b10010;
  localparam logic [4:0] SEL_SGT = 5'b10011;
  localparam logic [4:0] SEL_SLE = 5'b10100;
  localparam logic [4:0] SEL_SGE = 5'b10110;

  logic [4:0]        w_sel;
  logic              w_legal;
  logic              w_is_r;
  logic              w_uses_rs2;
  logic              w_hazard;
  logic              w_accept;
  logic [DATA_W-1:0] w_imm_ext;
  logic [DATA_W-1:0] w_in1;
  logic [DATA_W-1:0] w_in2;

  logic              r_valid;
  logic [DATA_W-1:0] r_in1;
  logic [DATA_W-1:0] r_in2;
  logic [4:0]        r_sel;
  logic [4:0]        r_rd;
  logic              r_wr_en;
  logic              r_illegal;

  // Youngest producer wins; register 0 always reads as zero.
  function automatic logic [DATA_W-1:0] fwd(
    input logic [4:0]        rs,
    input logic [DATA_W-1:0] rf_data,
    input logic              em_en,
    input logic [4:0]        em_rd,
    input logic [DATA_W-1:0] em_data,
    input logic              mw_en,
    input logic [4:0]        mw_rd,
    input logic [DATA_W-1:0] mw_data
  );
    if (rs == 5'd0)                  return '0;
    else if (em_en && em_rd == rs)   return em_data;
    else if (mw_en && mw_rd == rs)   return mw_data;
    else                             return rf_data;
  endfunction

  always_comb begin
    w_sel   = SEL_ADD;
    w_legal = 1'b1;
    w_is_r  = (in_opcode == 6'h00);
    if (w_is_r) begin
      case (in_func)
        6'h20, 6'h21: w_sel = SEL_ADD;
        6'h22, 6'h23: w_sel = SEL_SUB;
        6'h28:        w_sel = SEL_SEQ;
        6'h29:        w_sel = SEL_SNE;
        6'h2A:        w_sel = SEL_SLT;
        6'h2B:        w_sel = SEL_SGT;
        6'h2C:        w_sel = SEL_SLE;
        6'h2D:        w_sel = SEL_SGE;
        default:      w_legal = 1'b0;
      endcase
    end else begin
      case (in_opcode)
        6'h08:   w_sel = SEL_ADD;
        6'h0A:   w_sel = SEL_SUB;
        6'h18:   w_sel = SEL_SEQ;
        6'h19:   w_sel = SEL_SNE;
        6'h1A:   w_sel = SEL_SLT;
        6'h1B:   w_sel = SEL_SGT;
        6'h1C:   w_sel = SEL_SLE;
        6'h1D:   w_sel = SEL_SGE;
        default: w_legal = 1'b0;
      endcase
    end
    if (!w_legal) w_sel = SEL_ADD;
  end

  assign w_uses_rs2 = w_legal && w_is_r;
  assign w_imm_ext  = {{(DATA_W-IMM_W){in_imm[IMM_W-1]}}, in_imm};

  assign w_in1 = fwd(in_rs1, in_rs1_data, exmem_wr_en, exmem_rd, exmem_data,
                     memwb_wr_en, memwb_rd, memwb_data);
  assign w_in2 = w_is_r ? fwd(in_rs2, in_rs2_data, exmem_wr_en, exmem_rd, exmem_data,
                              memwb_wr_en, memwb_rd, memwb_data)
                        : w_imm_ext;

  // Illegal instructions read no sources, so they never stall on a load.
  assign w_hazard = in_valid && ex_load_pending && (ex_load_rd != 5'd0) &&
                    ((w_legal && ex_load_rd == in_rs1) ||
                     (w_uses_rs2 && ex_load_rd == in_rs2));

  assign in_ready = !w_hazard && (!r_valid || out_ready);
  assign w_accept = in_valid && in_ready && !flush;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_valid   <= 1'b0;
      r_in1     <= '0;
      r_in2     <= '0;
      r_sel     <= '0;
      r_rd      <= '0;
      r_wr_en   <= 1'b0;
      r_illegal <= 1'b0;
    end else if (flush) begin
      r_valid <= 1'b0;
    end else if (w_accept) begin
      r_valid   <= 1'b1;
      r_in1     <= w_in1;
      r_in2     <= w_in2;
      r_sel     <= w_sel;
      r_rd      <= in_rd;
      r_wr_en   <= w_legal && (in_rd != 5'd0);
      r_illegal <= !w_legal;
    end else if (out_ready) begin
      r_valid <= 1'b0;
    end
  end

  assign out_valid   = r_valid;
  assign out_in1     = r_in1;
  assign out_in2     = r_in2;
  assign out_sel     = r_sel;
  assign out_rd      = r_rd;
  assign out_wr_en   = r_wr_en;
  assign out_illegal = r_illegal;

`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] r_issued;
  logic [31:0] r_stalls;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_issued <= '0;
      r_stalls <= '0;
    end else begin
      if (w_accept && r_issued != 32'hFFFF_FFFF)
        r_issued <= r_issued + 32'd1;
      if (in_valid && !in_ready && r_stalls != 32'hFFFF_FFFF)
        r_stalls <= r_stalls + 32'd1;
    end
  end

  assign stat_issued = r_issued;
  assign stat_stalls = r_stalls;
`endif

endmodule

// File: tb/tb_alu_issue_stage.sv
// Directed-vector bench for alu_issue_stage; one task per scenario.
module tb_alu_issue_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid;
  logic        in_ready;
  logic [5:0]  in_opcode;
  logic [5:0]  in_func;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [31:0] in_rs1_data, in_rs2_data;
  logic [15:0] in_imm;
  logic        exmem_wr_en;
  logic [4:0]  exmem_rd;
  logic [31:0] exmem_data;
  logic        memwb_wr_en;
  logic [4:0]  memwb_rd;
  logic [31:0] memwb_data;
  logic        ex_load_pending;
  logic [4:0]  ex_load_rd;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_in1, out_in2;
  logic [4:0]  out_sel;
  logic [4:0]  out_rd;
  logic        out_wr_en;
  logic        out_illegal;
`ifdef ALU_ISSUE_STATS_EN
  logic [31:0] stat_issued;
  logic [31:0] stat_stalls;
`endif

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_issue_stage dut (
    .clk(clk), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_opcode(in_opcode), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd),
    .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .exmem_wr_en(exmem_wr_en), .exmem_rd(exmem_rd), .exmem_data(exmem_data),
    .memwb_wr_en(memwb_wr_en), .memwb_rd(memwb_rd), .memwb_data(memwb_data),
    .ex_load_pending(ex_load_pending), .ex_load_rd(ex_load_rd),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_in1(out_in1), .out_in2(out_in2), .out_sel(out_sel),
    .out_rd(out_rd), .out_wr_en(out_wr_en), .out_illegal(out_illegal)
`ifdef ALU_ISSUE_STATS_EN
    , .stat_issued(stat_issued), .stat_stalls(stat_stalls)
`endif
  );

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_idle;
    in_valid = 0; in_opcode = 0; in_func = 6'h20;
    in_rs1 = 0; in_rs2 = 0; in_rd = 0;
    in_rs1_data = 0; in_rs2_data = 0; in_imm = 0;
    exmem_wr_en = 0; exmem_rd = 0; exmem_data = 0;
    memwb_wr_en = 0; memwb_rd = 0; memwb_data = 0;
    ex_load_pending = 0; ex_load_rd = 0; flush = 0; out_ready = 1;
  endtask

  task automatic drive_op(input logic [5:0] op, input logic [5:0] fn,
                          input logic [4:0] rs1, input logic [4:0] rs2, input logic [4:0] rd,
                          input logic [31:0] d1, input logic [31:0] d2, input logic [15:0] imm);
    in_valid = 1; in_opcode = op; in_func = fn;
    in_rs1 = rs1; in_rs2 = rs2; in_rd = rd;
    in_rs1_data = d1; in_rs2_data = d2; in_imm = imm;
  endtask

  task automatic test_reset;
    set_idle();
    reset = 1;
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b want=0", out_valid); end
    total++; if (out_in1 !== 32'd0 || out_in2 !== 32'd0) begin bad++; $display("FAIL reset_ops got=%h/%h want=0/0", out_in1, out_in2); end
    total++; if (out_sel !== 5'd0 || out_rd !== 5'd0 || out_wr_en !== 1'b0 || out_illegal !== 1'b0) begin
      bad++; $display("FAIL reset_ctl got sel=%b rd=%0d wr=%0b ill=%0b want all 0", out_sel, out_rd, out_wr_en, out_illegal); end
    reset = 0;
    tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_ready got=%0b want=1", in_ready); end
`ifdef ALU_ISSUE_STATS_EN
    total++; if (stat_issued !== 32'd0 || stat_stalls !== 32'd0) begin bad++; $display("FAIL reset_stats got=%0d/%0d want=0/0", stat_issued, stat_stalls); end
`endif
    $display("txn reset done");
  endtask

  task automatic test_sgei;
    set_idle();
    drive_op(6'h1D, 6'h00, 5'd1, 5'd0, 5'd2, 32'd5, 32'd0, 16'hFFFF);
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL sgei_valid got=%0b want=1", out_valid); end
    total++; if (out_in1 !== 32'd5 || out_in2 !== 32'hFFFF_FFFF) begin bad++; $display("FAIL sgei_ops got=%h/%h want=00000005/ffffffff", out_in1, out_in2); end
    total++; if (out_sel !== 5'b10110 || out_wr_en !== 1'b1 || out_rd !== 5'd2) begin
      bad++; $display("FAIL sgei_ctl got sel=%b wr=%0b rd=%0d want 10110/1/2", out_sel, out_wr_en, out_rd); end
    $display("txn sgei in1=%h in2=%h sel=%b", out_in1, out_in2, out_sel);
  endtask

  task automatic test_forward;
    set_idle();
    drive_op(6'h00, 6'h22, 5'd3, 5'd3, 5'd6, 32'd1, 32'd2, 16'h0);
    exmem_wr_en = 1; exmem_rd = 3; exmem_data = 32'd7;
    memwb_wr_en = 1; memwb_rd = 3; memwb_data = 32'd9;
    tick();
    total++; if (out_in1 !== 32'd7 || out_in2 !== 32'd7 || out_sel !== 5'b11000) begin
      bad++; $display("FAIL fwd_exmem got=%h/%h sel=%b want=7/7 11000", out_in1, out_in2, out_sel); end
    $display("txn fwd_exmem in1=%h in2=%h", out_in1, out_in2);
    // MEM/WB only for rs1; rs2 is r0 so reads zero despite nonzero RF data
    set_idle();
    drive_op(6'h00, 6'h20, 5'd5, 5'd0, 5'd6, 32'h1111, 32'h1234, 16'h0);
    exmem_wr_en = 1; exmem_rd = 5'd7; exmem_data = 32'hDEAD;
    memwb_wr_en = 1; memwb_rd = 5'd5; memwb_data = 32'h55;
    tick();
    in_valid = 0;
    total++; if (out_in1 !== 32'h55 || out_in2 !== 32'd0) begin
      bad++; $display("FAIL fwd_memwb got=%h/%h want=00000055/00000000", out_in1, out_in2); end
    $display("txn fwd_memwb in1=%h in2=%h", out_in1, out_in2);
  endtask

  task automatic test_hazard;
    logic [31:0] s0;
    set_idle();
`ifdef ALU_ISSUE_STATS_EN
    s0 = stat_stalls;
`else
    s0 = 0;
`endif
    drive_op(6'h00, 6'h20, 5'd1, 5'd4, 5'd8, 32'h10, 32'h44, 16'h0);
    ex_load_pending = 1; ex_load_rd = 4;
    #1;
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL hazard_ready got=%0b want=0", in_ready); end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL hazard_valid got=%0b want=0", out_valid); end
`ifdef ALU_ISSUE_STATS_EN
    total++; if (stat_stalls !== s0 + 32'd1) begin bad++; $display("FAIL hazard_stall got=%0d want=%0d", stat_stalls, s0 + 32'd1); end
`endif
    ex_load_pending = 0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL hazard_release got=%0b want=1", in_ready); end
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1 || out_in1 !== 32'h10 || out_in2 !== 32'h44) begin
      bad++; $display("FAIL hazard_issue got v=%0b %h/%h want 1 00000010/00000044", out_valid, out_in1, out_in2); end
    $display("txn hazard stall_base=%0d in2=%h", s0, out_in2);
  endtask

  task automatic test_backpressure;
    set_idle();
    drive_op(6'h00, 6'h20, 5'd1, 5'd2, 5'd3, 32'h11, 32'h22, 16'h0);
    tick();
    out_ready = 0;
    for (int i = 0; i < 3; i++) begin
      drive_op(6'h08, 6'h00, 5'd9, 5'd0, 5'd10, 32'h100 + i, 32'h0, 16'h5);
      #1;
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready%0d got=%0b want=0", i, in_ready); end
      tick();
      total++; if (out_valid !== 1'b1 || out_in1 !== 32'h11 || out_in2 !== 32'h22 || out_rd !== 5'd3) begin
        bad++; $display("FAIL bp_hold%0d got v=%0b %h/%h rd=%0d want 1 00000011/00000022 rd=3", i, out_valid, out_in1, out_in2, out_rd); end
      $display("txn bp_hold cycle=%0d in1=%h", i, out_in1);
    end
    out_ready = 1;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_release got=%0b want=1", in_ready); end
    tick();
    in_valid = 0;
    total++; if (out_in1 !== 32'h102 || out_in2 !== 32'h5 || out_rd !== 5'd10) begin
      bad++; $display("FAIL bp_next got=%h/%h rd=%0d want 00000102/00000005 rd=10", out_in1, out_in2, out_rd); end
    $display("txn bp_next in1=%h", out_in1);
  endtask

  task automatic test_illegal;
    set_idle();
    drive_op(6'h3F, 6'h20, 5'd1, 5'd2, 5'd5, 32'h1, 32'h2, 16'h0);
    tick();
    total++; if (out_illegal !== 1'b1 || out_wr_en !== 1'b0 || out_sel !== 5'b00000) begin
      bad++; $display("FAIL illegal got ill=%0b wr=%0b sel=%b want 1/0/00000", out_illegal, out_wr_en, out_sel); end
    $display("txn illegal op=3f ill=%0b", out_illegal);
    drive_op(6'h00, 6'h21, 5'd1, 5'd2, 5'd0, 32'h1, 32'h2, 16'h0);
    tick();
    in_valid = 0;
    total++; if (out_wr_en !== 1'b0 || out_illegal !== 1'b0 || out_valid !== 1'b1) begin
      bad++; $display("FAIL rd0 got wr=%0b ill=%0b v=%0b want 0/0/1", out_wr_en, out_illegal, out_valid); end
    $display("txn add_rd0 wr=%0b", out_wr_en);
  endtask

  task automatic test_back_to_back;
    set_idle();
    drive_op(6'h0A, 6'h00, 5'd1, 5'd0, 5'd4, 32'h20, 32'h0, 16'h7FFF);
    tick();
    total++; if (out_in2 !== 32'h0000_7FFF || out_sel !== 5'b11000) begin
      bad++; $display("FAIL b2b_subi got in2=%h sel=%b want 00007fff/11000", out_in2, out_sel); end
    $display("txn b2b subi in2=%h", out_in2);
    drive_op(6'h1A, 6'h00, 5'd2, 5'd0, 5'd5, 32'h30, 32'h0, 16'h8000);
    tick();
    total++; if (out_in1 !== 32'h30 || out_in2 !== 32'hFFFF_8000 || out_sel !== 5'b10010) begin
      bad++; $display("FAIL b2b_slti got=%h/%h sel=%b want 00000030/ffff8000/10010", out_in1, out_in2, out_sel); end
    $display("txn b2b slti in2=%h", out_in2);
    drive_op(6'h00, 6'h2B, 5'd3, 5'd4, 5'd6, 32'h40, 32'h50, 16'h0);
    tick();
    in_valid = 0;
    total++; if (out_in1 !== 32'h40 || out_in2 !== 32'h50 || out_sel !== 5'b10011 || out_valid !== 1'b1) begin
      bad++; $display("FAIL b2b_sgt got=%h/%h sel=%b v=%0b want 00000040/00000050/10011/1", out_in1, out_in2, out_sel, out_valid); end
    $display("txn b2b sgt sel=%b", out_sel);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL b2b_drain got=%0b want=0", out_valid); end
  endtask

  task automatic test_flush;
    set_idle();
    drive_op(6'h08, 6'h00, 5'd1, 5'd0, 5'd2, 32'h1, 32'h0, 16'h1);
    tick();
    out_ready = 0; flush = 1;
    drive_op(6'h08, 6'h00, 5'd1, 5'd0, 5'd3, 32'h2, 32'h0, 16'h2);
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_valid got=%0b want=0", out_valid); end
    flush = 0; in_valid = 0; out_ready = 1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL flush_noaccept got=%0b want=0", out_valid); end
    $display("txn flush v=%0b", out_valid);
    drive_op(6'h08, 6'h00, 5'd1, 5'd0, 5'd2, 32'h3, 32'h0, 16'h3);
    out_ready = 0;
    tick();
    in_valid = 0;
    total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL areset_pre got=%0b want=1", out_valid); end
    #1 reset = 1;
    #1;
    total++; if (out_valid !== 1'b0 || out_in1 !== 32'd0) begin
      bad++; $display("FAIL areset got v=%0b in1=%h want 0/00000000", out_valid, out_in1); end
    reset = 0;
    out_ready = 1;
    $display("txn async_reset v=%0b", out_valid);
  endtask

  initial begin
    test_reset();
    test_sgei();
    test_forward();
    test_hazard();
    test_backpressure();
    test_illegal();
    test_back_to_back();
    test_flush();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_issue_stage.md
Name: alu_issue_stage

Overview:
- ID/EX boundary stage directly upstream of the 32-bit arithmetic ALU (ADD, SUB, SEQ, SNE, SLT, SGT, SLE, SGE).
- Decodes the DLX opcode/func into the ALU's five select lines and picks operand B (register or sign-extended immediate).
- Forwards results from EX/MEM and MEM/WB, detects load-use hazards, and registers everything into one valid/ready pipeline register.
- The ALU consumes the registered outputs combinationally in the next cycle.

Parameters:
- DATA_W, 32: operand width; only 32 is supported.
- IMM_W, 16: immediate field width; sign-extended to DATA_W.

Ports:
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  stage accepts this cycle
- in_opcode  in  6  DLX opcode
- in_func  in  6  R-type func
- in_rs1, in_rs2, in_rd  in  5 each  register indices
- in_rs1_data, in_rs2_data  in  32 each  register-file read data
- in_imm  in  16  immediate
- exmem_wr_en  in  1; exmem_rd  in  5; exmem_data  in  32  EX/MEM writeback
- memwb_wr_en  in  1; memwb_rd  in  5; memwb_data  in  32  MEM/WB writeback
- ex_load_pending  in  1; ex_load_rd  in  5  load occupying EX
- flush  in  1  kill the held and incoming instruction
- out_valid  out  1; out_ready  in  1  downstream handshake
- out_in1, out_in2  out  32 each  ALU operands
- out_sel  out  5  out_sel[k] drives ALU selk
- out_rd  out  5; out_wr_en  out  1; out_illegal  out  1

Behaviour:
- Reset: out_valid=0. All other registered outputs are 0. in_ready is combinational and equals 1 after reset unless a hazard is present.
- Decode, R-type (opcode 0x00):
  - func 0x20/0x21 ADD -> 5'b00000
  - func 0x22/0x23 SUB -> 5'b11000
  - SEQ 0x28 -> 10000; SNE 0x29 -> 10001; SLT 0x2A -> 10010; SGT 0x2B -> 10011; SLE 0x2C -> 10100; SGE 0x2D -> 10110
  - Bit strings are {sel4,sel3,sel2,sel1,sel0}. Don't-care selects are driven 0.
- Decode, I-type: ADDI 0x08, SUBI 0x0A, SEQI 0x18, SNEI 0x19, SLTI 0x1A, SGTI 0x1B, SLEI 0x1C, SGEI 0x1D use the same select codes as their R-type forms. Operand B is the sign-extended imm. Destination is in_rd for both formats.
- Anything else: out_illegal=1, out_sel=ADD, out_wr_en=0.
- Forwarding, per source operand:
  - rs==0 gives 0.
  - Otherwise, on an EX/MEM match (wr_en && rd==rs), use exmem_data.
  - Otherwise, on a MEM/WB match, use memwb_data.
  - Otherwise, use the register-file data.
  - EX/MEM wins when both match. rs2 is forwarded only for R-type.
- Hazard: asserted when in_valid && ex_load_pending && ex_load_rd!=0 && ex_load_rd equals a used source. Hazard forces in_ready=0.
- Handshake: in_ready = !hazard && (!out_valid || out_ready).
  - Accept: in_valid && in_ready. Registers load and out_valid<=1.
  - Downstream takes the instruction and nothing is accepted: out_valid<=0.
  - Outputs hold stable while out_valid && !out_ready.
- Flush has priority over everything: out_valid<=0 next edge and nothing is accepted that cycle.
- out_wr_en=1 for every legal op with rd!=0.
- Reset asserted mid-stall clears state immediately, independent of clk.
- Latency: 1 cycle from accept to out_valid. Throughput: 1 per cycle with no stalls.

Optional Feature:
- Macro ALU_ISSUE_STATS_EN.
- When defined: adds outputs stat_issued[31:0] (count of accepts) and stat_stalls[31:0] (cycles with in_valid && !in_ready).
  - Both counters saturate at 0xFFFFFFFF.
  - reset clears both; flush does not.
- When undefined: neither port nor counter exists; behaviour is otherwise identical.

Test Plan:
- SGEI, rs1 data=5, imm=0xFFFF, no forwarding, out_ready=1 -> next cycle out_valid=1, out_in1=5, out_in2=0xFFFFFFFF, out_sel=10110.
- R-type SUB rs1=3, rs2=3, exmem_rd=3 with data 7, memwb_rd=3 with data 9 -> out_in1=out_in2=7, out_sel=11000.
- ex_load_pending=1, ex_load_rd=4, ADD using rs2=4 -> in_ready=0, out_valid drops, and a stall is counted. Releasing the load -> accept on that cycle.
- out_ready=0 for 3 cycles with a new in_valid each cycle -> outputs frozen and in_ready=0; out_ready=1 -> next instruction appears one cycle later.
- Opcode 0x3F -> out_illegal=1, out_wr_en=0, out_sel=00000. rd=0 ADD -> out_wr_en=0.
- flush asserted together with in_valid while holding an instruction -> out_valid=0 next cycle. reset pulsed between edges -> out_valid=0 immediately.
